// File: rtl/seg_scan_multi.sv
// Multiplexed seven-segment driver: captures a magnitude, converts it to BCD or hex
// digits with a serial double-dabble, and scans the stored frame one digit per ms.
module seg_scan_multi #(
    parameter int DIG_NUM   = 6,
    parameter int DATA_W    = 20,
    parameter int CNT_1MS   = 49_999,
    parameter int CNT_BLINK = 499
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [DATA_W-1:0]  data,
    input  logic [DIG_NUM-1:0] point,
    input  logic               sign,
    input  logic               hex_mode,
    input  logic [DIG_NUM-1:0] blink,
    input  logic               data_vld,
    input  logic               seg_en,
    output logic               busy,
    output logic               ovf,
    output logic [7:0]         seg,
    output logic [DIG_NUM-1:0] sel
);

    // Three spare BCD digits hold any DATA_W <= 4*DIG_NUM value, so overflow is always visible.
    localparam int BCD_DIG = DIG_NUM + 3;
    localparam int BCD_W   = 4 * BCD_DIG;
    localparam int BIT_CW  = $clog2(DATA_W + 1);
    localparam int MS_CW   = (CNT_1MS > 0) ? $clog2(CNT_1MS + 1) : 1;
    localparam int BL_CW   = (CNT_BLINK > 0) ? $clog2(CNT_BLINK + 1) : 1;
    localparam int IDX_W   = $clog2(DIG_NUM);

    localparam logic [DIG_NUM-1:0][7:0] FRAME_RST = {{(DIG_NUM-1){8'hFF}}, 8'hC0};

    // input shadow
    logic [DIG_NUM-1:0]        point_in_q;
    logic                      sign_in_q;
    logic                      hex_in_q;
    logic [DIG_NUM-1:0]        blink_in_q;

    // conversion state
    logic                      busy_q;
    logic [BIT_CW-1:0]         bit_cnt_q;
    logic [DATA_W-1:0]         sh_q, sh_d;
    logic [BCD_W-1:0]          bcd_q, bcd_d, bcd_adj;

    // display shadow
    logic [DIG_NUM-1:0][7:0]   frame_q, frame_d;
    logic [DIG_NUM-1:0]        disp_blink_q;
    logic                      disp_ovf_q, ovf_d;

    // scan state
    logic [MS_CW-1:0]          cnt_1ms_q;
    logic [IDX_W-1:0]          dig_idx_q;
    logic [BL_CW-1:0]          blink_cnt_q;
    logic                      blink_phase_q;
    logic [7:0]                seg_q, seg_d;
    logic [DIG_NUM-1:0]        sel_q, sel_d;

    int                        msd;
    int                        top;
    logic                      neg;

    function automatic logic [7:0] enc7(input logic [3:0] v);
        logic [7:0] c;
        case (v)
            4'h0: c = 8'hC0;
            4'h1: c = 8'hF9;
            4'h2: c = 8'hA4;
            4'h3: c = 8'hB0;
            4'h4: c = 8'h99;
            4'h5: c = 8'h92;
            4'h6: c = 8'h82;
            4'h7: c = 8'hF8;
            4'h8: c = 8'h80;
            4'h9: c = 8'h90;
            4'hA: c = 8'h88;
            4'hB: c = 8'h83;
            4'hC: c = 8'hC6;
            4'hD: c = 8'hA1;
            4'hE: c = 8'h86;
            default: c = 8'h8E;
        endcase
        return c;
    endfunction

    // Hex mode skips the add-3 correction so the shift register simply collects nibbles.
    always_comb begin
        bcd_adj = bcd_q;
        if (!hex_in_q) begin
            for (int k = 0; k < BCD_DIG; k++) begin
                if (bcd_adj[4*k +: 4] >= 4'd5)
                    bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] + 4'd3;
            end
        end
        bcd_d = {bcd_adj[BCD_W-2:0], sh_q[DATA_W-1]};
        sh_d  = {sh_q[DATA_W-2:0], 1'b0};
    end

    always_comb begin
        msd     = 0;
        top     = 0;
        neg     = 1'b0;
        ovf_d   = 1'b0;
        frame_d = '1;
        for (int k = 0; k < BCD_DIG; k++) begin
            if (bcd_q[4*k +: 4] != 4'd0)
                msd = k;
        end
        neg   = sign_in_q && (bcd_q != '0);
        ovf_d = neg ? (msd >= DIG_NUM - 1) : (msd >= DIG_NUM);
        top   = msd;
        for (int k = 0; k < DIG_NUM; k++) begin
            if (point_in_q[k] && (k > top))
                top = k;
        end
        for (int k = 0; k < DIG_NUM; k++) begin
            if (ovf_d)
                frame_d[k] = 8'h86;
            else if (k <= top)
                frame_d[k] = enc7(bcd_q[4*k +: 4]);
            else if (neg && (k == top + 1))
                frame_d[k] = 8'hBF;
            else
                frame_d[k] = 8'hFF;
            if (point_in_q[k])
                frame_d[k][7] = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            point_in_q   <= '0;
            sign_in_q    <= 1'b0;
            hex_in_q     <= 1'b0;
            blink_in_q   <= '0;
            busy_q       <= 1'b0;
            bit_cnt_q    <= '0;
            sh_q         <= '0;
            bcd_q        <= '0;
            frame_q      <= FRAME_RST;
            disp_blink_q <= '0;
            disp_ovf_q   <= 1'b0;
        end else if (!busy_q) begin
            if (data_vld) begin
                point_in_q <= point;
                sign_in_q  <= sign;
                hex_in_q   <= hex_mode;
                blink_in_q <= blink;
                sh_q       <= data;
                bcd_q      <= '0;
                bit_cnt_q  <= '0;
                busy_q     <= 1'b1;
            end
        end else if (bit_cnt_q == BIT_CW'(DATA_W)) begin
            // all bits shifted in: publish the whole frame in one edge
            busy_q       <= 1'b0;
            frame_q      <= frame_d;
            disp_ovf_q   <= ovf_d;
            disp_blink_q <= blink_in_q;
        end else begin
            bcd_q     <= bcd_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_1ms_q     <= '0;
            dig_idx_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (cnt_1ms_q == MS_CW'(CNT_1MS)) begin
            cnt_1ms_q <= '0;
            dig_idx_q <= (dig_idx_q == IDX_W'(DIG_NUM - 1)) ? '0 : dig_idx_q + 1'b1;
            if (blink_cnt_q == BL_CW'(CNT_BLINK)) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end else begin
            cnt_1ms_q <= cnt_1ms_q + 1'b1;
        end
    end

    always_comb begin
        seg_d            = frame_q[dig_idx_q];
        sel_d            = '0;
        sel_d[dig_idx_q] = 1'b1;
        if (disp_blink_q[dig_idx_q] && blink_phase_q)
            seg_d = 8'hFF;
        if (!seg_en) begin
            seg_d = 8'hFF;
            sel_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            seg_q <= 8'hFF;
            sel_q <= '0;
        end else begin
            seg_q <= seg_d;
            sel_q <= sel_d;
        end
    end

    assign busy = busy_q;
    assign ovf  = disp_ovf_q;
    assign seg  = seg_q;
    assign sel  = sel_q;

endmodule

// File: tb/tb_seg_scan_multi.sv
// Bench for seg_scan_multi: directed and random frames checked every cycle against
// an arithmetic model of the displayed digits and of the scan/blink timing.
module tb_seg_scan_multi;

    localparam int DIG_NUM   = 6;
    localparam int DATA_W    = 20;
    localparam int CNT_1MS   = 210;
    localparam int CNT_BLINK = 4;
    localparam int TICK      = CNT_1MS + 1;
    localparam int FRAME_CYC = DIG_NUM * TICK + 4;

    logic               sys_clk = 1'b0;
    logic               sys_rst_n = 1'b0;
    logic [DATA_W-1:0]  data = '0;
    logic [DIG_NUM-1:0] point = '0;
    logic               sign = 1'b0;
    logic               hex_mode = 1'b0;
    logic [DIG_NUM-1:0] blink = '0;
    logic               data_vld = 1'b0;
    logic               seg_en = 1'b1;
    logic               busy;
    logic               ovf;
    logic [7:0]         seg;
    logic [DIG_NUM-1:0] sel;

    seg_scan_multi #(
        .DIG_NUM(DIG_NUM), .DATA_W(DATA_W), .CNT_1MS(CNT_1MS), .CNT_BLINK(CNT_BLINK)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data), .point(point),
        .sign(sign), .hex_mode(hex_mode), .blink(blink), .data_vld(data_vld),
        .seg_en(seg_en), .busy(busy), .ovf(ovf), .seg(seg), .sel(sel)
    );

    always #5 sys_clk = ~sys_clk;

    int   checks = 0;
    int   failures = 0;
    int   ncyc = 0;
    logic en_last = 1'b1;
    bit   saw_blank = 1'b0;
    bit   saw_lit = 1'b0;

    // edges since reset release, and seg_en as the DUT last sampled it
    always @(posedge sys_clk) begin
        ncyc    <= sys_rst_n ? ncyc + 1 : 0;
        en_last <= seg_en;
    end

    // currently displayed frame
    int               s_data = 0;
    logic [DIG_NUM-1:0] s_pt = '0;
    bit               s_sg = 1'b0;
    bit               s_hx = 1'b0;
    logic [DIG_NUM-1:0] s_bl = '0;

    logic [7:0] ENC [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic int nsig_of(input int d, input bit hx);
        int base;
        int n;
        int v;
        base = hx ? 16 : 10;
        n = 1;
        v = d;
        while (v >= base) begin
            v = v / base;
            n++;
        end
        return n;
    endfunction

    function automatic bit exp_ovf(input int d, input bit sg, input bit hx);
        bit neg;
        neg = sg && (d != 0);
        return nsig_of(d, hx) > (neg ? DIG_NUM - 1 : DIG_NUM);
    endfunction

    function automatic logic [7:0] exp_seg(input int d, input logic [DIG_NUM-1:0] pt,
                                           input bit sg, input bit hx, input int i);
        int base;
        int v;
        int top;
        bit neg;
        logic [7:0] c;
        base = hx ? 16 : 10;
        v = d;
        for (int k = 0; k < i; k++) v = v / base;
        neg = sg && (d != 0);
        top = nsig_of(d, hx) - 1;
        for (int k = 0; k < DIG_NUM; k++)
            if (pt[k] && k > top) top = k;
        if (exp_ovf(d, sg, hx))       c = 8'h86;
        else if (i <= top)            c = ENC[v % base];
        else if (neg && i == top + 1) c = 8'hBF;
        else                          c = 8'hFF;
        if (pt[i]) c[7] = 1'b0;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scan position and blink phase follow from the edge count: the digit index after
    // k edges is (k / TICK) mod DIG_NUM, and outputs lag that by one edge.
    task automatic check_out(input string tag);
        int k;
        int d;
        bit ph;
        logic [7:0] es;
        logic [DIG_NUM-1:0] esel;
        k  = ncyc - 1;
        d  = (k / TICK) % DIG_NUM;
        ph = (((k / TICK) / (CNT_BLINK + 1)) % 2) == 1;
        if (!en_last) begin
            es   = 8'hFF;
            esel = '0;
        end else begin
            esel = DIG_NUM'(1) << d;
            es   = (s_bl[d] && ph) ? 8'hFF : exp_seg(s_data, s_pt, s_sg, s_hx, d);
            if (d == 0 && s_bl[0]) begin
                if (ph) saw_blank = 1'b1;
                else    saw_lit = 1'b1;
            end
        end
        chk({tag, "_sel"}, 32'(sel), 32'(esel));
        chk({tag, "_seg"}, 32'(seg), 32'(es));
    endtask

    task automatic run_cycles(input int n, input string tag);
        repeat (n) begin
            @(negedge sys_clk);
            check_out(tag);
        end
    endtask

    // Called just after a negedge; returns on the negedge where busy has fallen.
    task automatic load(input int d, input logic [DIG_NUM-1:0] pt, input bit sg,
                        input bit hx, input logic [DIG_NUM-1:0] bl, input bit inject);
        int bc;
        data     = DATA_W'(d);
        point    = pt;
        sign     = sg;
        hex_mode = hx;
        blink    = bl;
        data_vld = 1'b1;
        @(negedge sys_clk);
        data_vld = 1'b0;
        bc = 0;
        while (busy === 1'b1 && bc < 64) begin
            check_out("busy_frame");
            chk("ovf_hold", 32'(ovf), 32'(exp_ovf(s_data, s_sg, s_hx)));
            if (inject && bc == 4) begin
                data     = data ^ 20'h5A5A5;
                sign     = ~sg;
                data_vld = 1'b1;
            end
            bc++;
            @(negedge sys_clk);
            data_vld = 1'b0;
        end
        chk("busy_len", 32'(bc), 32'(DATA_W + 1));
        check_out("fall_frame");
        s_data = d;
        s_pt   = pt;
        s_sg   = sg;
        s_hx   = hx;
        s_bl   = bl;
        chk("ovf", 32'(ovf), 32'(exp_ovf(d, sg, hx)));
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("rst_seg", 32'(seg), 32'h0FF);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        sys_rst_n = 1'b1;
        run_cycles(FRAME_CYC, "frame0");

        load(9876, '0, 0, 0, '0, 0);           run_cycles(FRAME_CYC, "dec9876");
        load(42, '0, 1, 0, '0, 0);             run_cycles(FRAME_CYC, "minus42");
        load(32'hABCDE, '0, 0, 1, '0, 0);      run_cycles(FRAME_CYC, "hex");
        load(1_000_000, '0, 0, 0, '0, 0);      run_cycles(FRAME_CYC, "ovf_dec");
        load(100_000, '0, 1, 0, '0, 0);        run_cycles(FRAME_CYC, "ovf_sign");
        load(5, 6'b000100, 0, 0, '0, 0);       run_cycles(FRAME_CYC, "point");
        load(0, '0, 1, 0, '0, 0);              run_cycles(FRAME_CYC, "zero_sign");
        load(123, 6'b000010, 1, 0, '0, 1);     run_cycles(FRAME_CYC, "ignore");

        for (int r = 0; r < 10; r++) begin
            int d;
            logic [DIG_NUM-1:0] pt;
            d  = int'($urandom_range(0, (1 << DATA_W) - 1));
            if (r % 3 == 0) d = int'($urandom_range(0, 999));
            pt = ($urandom_range(0, 3) == 0) ? DIG_NUM'($urandom) : '0;
            load(d, pt, 1'($urandom), 1'($urandom), '0, 0);
            run_cycles(FRAME_CYC, "rand");
        end

        load(7, '0, 0, 0, 6'b000001, 0);
        run_cycles(4 * DIG_NUM * TICK, "blink");
        chk("blink_blank_seen", 32'(saw_blank), 32'h1);
        chk("blink_lit_seen", 32'(saw_lit), 32'h1);

        seg_en = 1'b0;
        run_cycles(5, "segen_off");
        load(321, '0, 0, 0, '0, 0);
        run_cycles(20, "segen_off");
        seg_en = 1'b1;
        run_cycles(FRAME_CYC, "segen_on");

        data     = DATA_W'(555_555);
        sign     = 1'b1;
        data_vld = 1'b1;
        @(negedge sys_clk);
        data_vld = 1'b0;
        repeat (9) begin
            chk("mid_busy", 32'(busy), 32'h1);
            @(negedge sys_clk);
        end
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ovf", 32'(ovf), 32'h0);
        chk("abort_seg", 32'(seg), 32'h0FF);
        chk("abort_sel", 32'(sel), 32'h0);
        sys_rst_n = 1'b1;
        s_data = 0;
        s_pt   = '0;
        s_sg   = 1'b0;
        s_hx   = 1'b0;
        s_bl   = '0;
        run_cycles(FRAME_CYC, "post_rst");
        chk("post_rst_busy", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_multi.md
SEG_SCAN_MULTI -- requirements
Module: seg_scan_multi

Interface
REQ-001 Parameter DIG_NUM, default 6: digit count; legal range 2..8.
REQ-002 Parameter DATA_W, default 20: magnitude width; legal range 4..4*DIG_NUM.
REQ-003 Parameter CNT_1MS, default 49_999: scan tick terminal count (1 ms at 50 MHz).
REQ-004 Parameter CNT_BLINK, default 499: scan ticks per blink half-period.
REQ-005 Port sys_clk, input, width 1: sole clock; all logic on its rising edge.
REQ-006 Port sys_rst_n, input, width 1: reset, synchronous, active-low.
REQ-007 Port data, input, width DATA_W: unsigned magnitude to display.
REQ-008 Port point, input, width DIG_NUM: per-digit decimal point; bit i set lights dp of digit i.
REQ-009 Port sign, input, width 1: 1 displays a leading minus.
REQ-010 Port hex_mode, input, width 1: 1 selects hexadecimal; 0 selects decimal.
REQ-011 Port blink, input, width DIG_NUM: per-digit blink enable.
REQ-012 Port data_vld, input, width 1: one-cycle strobe capturing data, point, sign, hex_mode and blink.
REQ-013 Port seg_en, input, width 1: 0 blanks the display.
REQ-014 Port busy, output, width 1: conversion in progress.
REQ-015 Port ovf, output, width 1: captured value does not fit the available digits.
REQ-016 Port seg, output, width 8: active-low segments; bit7 dp, bits6..0 g..a.
REQ-017 Port sel, output, width DIG_NUM: one-hot active-high digit select; sel[0] is the rightmost digit.

Function
REQ-018 Capture: data_vld with busy=0 latches all inputs into an input shadow; busy rises the next cycle.
REQ-019 Ignore rule: data_vld while busy=1 is ignored.
REQ-020 Conversion: sequential double-dabble, one shift per cycle, in both modes; busy stays high exactly DATA_W+1 cycles.
REQ-021 Hex mode: digits are data nibbles; conversion cycle count is unchanged (uniform latency).
REQ-022 Display update: on the cycle busy falls, the display shadow (digits, point, sign, blink, ovf) updates atomically; until then the previous frame is shown.
REQ-023 Overflow: ovf=1 when significant digits exceed DIG_NUM (sign=0) or DIG_NUM-1 (sign=1); every digit then shows E (0x86), dp and blink still apply.
REQ-024 Leading-zero blanking: digits above the most significant nonzero digit show 0xFF.
REQ-025 Blanking exception: digit i and all lower digits are never blanked if point[i]=1.
REQ-026 Zero value: value 0 shows 0 on digit 0 only, and sign is ignored.
REQ-027 Minus placement: sign=1 puts minus (0xBF) on the digit directly left of the highest displayed digit.
REQ-028 Encoding, digits 0-F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
REQ-029 Decimal point: a lit dp clears bit7.
REQ-030 Scan counter: cnt_1ms counts 0..CNT_1MS and wraps.
REQ-031 Digit advance: at the wrap the digit index advances, DIG_NUM-1 wraps to 0.
REQ-032 Output registering: seg and sel are registered and change on the same edge, one cycle after the index change.
REQ-033 Blink timer: blink_phase toggles every CNT_BLINK+1 scan ticks.
REQ-034 Blink blanking: a digit with blink=1 and blink_phase=1 outputs seg=0xFF, including dp; sel still drives that digit.
REQ-035 seg_en=0: sel=0 and seg=0xFF from the next edge; counters, conversion and capture keep running.

Reset
REQ-036 Reset output values: while sys_rst_n=0 at an edge, seg=0xFF, sel=0, busy=0 and ovf=0.
REQ-037 Reset state: cnt_1ms, digit index and blink_phase are cleared; both shadows are cleared, so the frame after reset is 0 on digit 0.
REQ-038 Reset mid-conversion: the conversion aborts and no display update occurs.

Verification
REQ-039 Decimal frame (CNT_1MS=210): data_vld, data=9876, sign=0, point=0 -> busy high 21 cycles, then digits3..0=90,80,F8,82 and digits5,4=FF; sel steps 000001->000010 every 211 cycles.
REQ-040 Minus: data=42, sign=1 -> digit2=BF, digit1=99, digit0=A4, digits5..3=FF, ovf=0.
REQ-041 Hex frame: hex_mode=1, data=20'hABCDE -> digits4..0=88,83,C6,A1,86, digit5=FF.
REQ-042 Overflow: data=1_000_000 -> ovf=1 and all digits 86; data=100_000 with sign=1 -> ovf=1.
REQ-043 Point: data=5, point=6'b000100 -> digit2=40, digit1=C0, digit0=92, upper digits FF.
REQ-044 Busy, blink, blanking and reset: data_vld during busy is ignored; blink=6'b000001 blanks digit0 on alternate half-periods; seg_en=0 gives sel=0 and seg=FF; reset at busy cycle 10 gives busy=0 and digit0=C0 next frame.
